// File: rtl/bch31_chien_locator_if.sv
// bch31_chien_locator_if: syndrome-in / error-mask-out handshake bundle.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

interface bch31_chien_locator_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  S1;
  logic [4:0]  S2;
  logic [4:0]  S3;
  logic [4:0]  S4;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] err_mask;
  logic [1:0]  err_count;
  logic        uncorrectable;

  modport master (
    output in_valid, S1, S2, S3, S4, out_ready,
    input  in_ready, out_valid, err_mask, err_count, uncorrectable
  );

  modport slave (
    input  in_valid, S1, S2, S3, S4, out_ready,
    output in_ready, out_valid, err_mask, err_count, uncorrectable
  );
endinterface

`default_nettype wire

// File: rtl/bch31_chien_locator.sv
// bch31_chien_locator: BCH(31,21) t=2 Peterson solve + 31-step Chien search.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module bch31_chien_locator #(
  parameter logic [5:0] PRIM_POLY = 6'b100101,
  parameter int         N         = 31
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  bch31_chien_locator_if.slave    bus
);

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[3:0], 1'b0} ^ (x[4] ? PRIM_POLY[4:0] : 5'd0);
    end
    return acc;
  endfunction

  // a^-1 = a^30 = a^2 * a^4 * a^8 * a^16; yields 0 for a == 0.
  function automatic logic [4:0] gf_inv(input logic [4:0] a);
    logic [4:0] a2, a4, a8, a16;
    a2  = gf_mul(a, a);
    a4  = gf_mul(a2, a2);
    a8  = gf_mul(a4, a4);
    a16 = gf_mul(a8, a8);
    return gf_mul(gf_mul(a2, a4), gf_mul(a8, a16));
  endfunction

  localparam logic [4:0] c_alpha_m1 = gf_inv(5'b00010);
  localparam logic [4:0] c_alpha_m2 = gf_mul(c_alpha_m1, c_alpha_m1);
  localparam logic [4:0] c_last_j   = 5'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SOLVE  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [4:0]  r_s1, r_s2, r_s3, r_s4;
  logic [4:0]  r_r1, r_r2;
  logic [4:0]  r_j;
  logic [1:0]  r_cnt;
  logic [1:0]  r_expected;
  logic        r_fail;
  logic [30:0] r_mask;
  logic        r_out_valid;
  logic [30:0] r_err_mask;
  logic [1:0]  r_err_count;
  logic        r_unc;

  logic        w_in_ready;
  logic [4:0]  w_s1_sq, w_s2_sq;
  logic        w_syn_bad;
  logic [4:0]  w_sigma1, w_sigma2, w_sigma2_raw;
  logic [1:0]  w_expected;
  logic        w_fail;
  logic        w_root;
  logic        w_unc;

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.err_mask      = r_err_mask;
  assign bus.err_count     = r_err_count;
  assign bus.uncorrectable = r_unc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = ST_SOLVE;
      end
      ST_SOLVE:  w_next_state = ST_SEARCH;
      ST_SEARCH: if (r_j == c_last_j) w_next_state = ST_DONE;
      ST_DONE:   if (r_out_valid && bus.out_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Peterson direct solution for t=2 on the captured syndromes.
  always_comb begin
    w_s1_sq      = gf_mul(r_s1, r_s1);
    w_s2_sq      = gf_mul(r_s2, r_s2);
    w_syn_bad    = (r_s2 != w_s1_sq) || (r_s4 != w_s2_sq);
    w_sigma2_raw = gf_mul(r_s3, gf_inv(r_s1)) ^ w_s1_sq;
    w_sigma1     = '0;
    w_sigma2     = '0;
    w_expected   = 2'd0;
    w_fail       = (r_s3 != 5'd0) || w_syn_bad;
    if (r_s1 != 5'd0) begin
      w_sigma1   = r_s1;
      w_sigma2   = w_sigma2_raw;
      w_expected = (w_sigma2_raw == 5'd0) ? 2'd1 : 2'd2;
      w_fail     = w_syn_bad;
    end
  end

  assign w_root = ((5'd1 ^ r_r1 ^ r_r2) == 5'd0);
  assign w_unc  = r_fail || (r_cnt != r_expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_s4        <= '0;
      r_r1        <= '0;
      r_r2        <= '0;
      r_j         <= '0;
      r_cnt       <= '0;
      r_expected  <= '0;
      r_fail      <= 1'b0;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
      r_err_mask  <= '0;
      r_err_count <= '0;
      r_unc       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_s1 <= bus.S1;
            r_s2 <= bus.S2;
            r_s3 <= bus.S3;
            r_s4 <= bus.S4;
          end
        end
        ST_SOLVE: begin
          r_r1       <= w_sigma1;
          r_r2       <= w_sigma2;
          r_j        <= '0;
          r_cnt      <= '0;
          r_mask     <= '0;
          r_expected <= w_expected;
          r_fail     <= w_fail;
        end
        ST_SEARCH: begin
          // r1/r2 track sigma1*alpha^-j and sigma2*alpha^-2j.
          if (w_root) begin
            r_mask <= r_mask | (31'd1 << r_j);
            if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
          end
          r_r1 <= gf_mul(r_r1, c_alpha_m1);
          r_r2 <= gf_mul(r_r2, c_alpha_m2);
          r_j  <= r_j + 5'd1;
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_unc       <= w_unc;
            r_err_mask  <= w_unc ? 31'd0 : r_mask;
            r_err_count <= w_unc ? 2'd0 : r_cnt;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bch31_chien_locator.sv
// tb_bch31_chien_locator: directed vector table plus backpressure and mid-search reset sequences.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_bch31_chien_locator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch31_chien_locator_if bus();

  bch31_chien_locator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  s1, s2, s3, s4;
    logic [30:0] mask;
    logic [1:0]  cnt;
    logic        unc;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] s3, input logic [4:0] s4);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.S1 = s1; bus.S2 = s2; bus.S3 = s3; bus.S4 = s4;
    @(posedge clk);
    #1;
    // Scramble inputs after the accepting edge; only that edge may matter.
    bus.in_valid = 1'b0;
    bus.S1 = ~s1; bus.S2 = ~s2; bus.S3 = ~s3; bus.S4 = ~s4;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'd33);
  endtask

  task automatic check_result(input string tag, input logic [30:0] mask,
                              input logic [1:0] cnt, input logic unc);
    check({tag, "_err_mask"},      32'(bus.err_mask),      32'(mask));
    check({tag, "_err_count"},     32'(bus.err_count),     32'(cnt));
    check({tag, "_uncorrectable"}, 32'(bus.uncorrectable), 32'(unc));
  endtask

  task automatic handoff(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_back"},  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string tag;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.S1 = '0; bus.S2 = '0; bus.S3 = '0; bus.S4 = '0;

    //            s1        s2        s3        s4        mask           cnt   unc
    vecs[0] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 31'h0,        2'd0, 1'b0};
    vecs[1] = '{5'b00101, 5'b10001, 5'b11111, 5'b01100, 31'h20,       2'd1, 1'b0};
    vecs[2] = '{5'b00011, 5'b00101, 5'b01001, 5'b10001, 31'h3,        2'd2, 1'b0};
    vecs[3] = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 31'h0,        2'd0, 1'b1};
    vecs[4] = '{5'b00001, 5'b00010, 5'b00000, 5'b00000, 31'h0,        2'd0, 1'b1};
    vecs[5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 31'h1,        2'd1, 1'b0};
    vecs[6] = '{5'b10010, 5'b01001, 5'b10110, 5'b01011, 31'h40000000, 2'd1, 1'b0};
    vecs[7] = '{5'b00110, 5'b10100, 5'b00010, 5'b11101, 31'h6,        2'd2, 1'b0};
    vecs[8] = '{5'b10011, 5'b01000, 5'b10111, 5'b01010, 31'h40000001, 2'd2, 1'b0};
    // sigma(x)=1+x+x^2 has no roots in GF(32): count falls short of expected.
    vecs[9] = '{5'b00001, 5'b00001, 5'b00000, 5'b00001, 31'h0,        2'd0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",      32'(bus.in_ready),      32'd1);
    check("rst_out_valid",     32'(bus.out_valid),     32'd0);
    check("rst_err_mask",      32'(bus.err_mask),      32'd0);
    check("rst_err_count",     32'(bus.err_count),     32'd0);
    check("rst_uncorrectable", 32'(bus.uncorrectable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      send(tag, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4);
      wait_result(tag);
      check_result(tag, vecs[i].mask, vecs[i].cnt, vecs[i].unc);
      handoff(tag);
    end

    // Backpressure: result must hold and new requests must be ignored.
    send("bp", 5'b00011, 5'b00101, 5'b01001, 5'b10001);
    wait_result("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.S1 = 5'b00001; bus.S2 = 5'b00001; bus.S3 = 5'b00001; bus.S4 = 5'b00001;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      tag = $sformatf("bp_hold%0d", k);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
      check_result(tag, 31'h3, 2'd2, 1'b0);
    end
    handoff("bp");
    send("bp_next", 5'b00101, 5'b10001, 5'b11111, 5'b01100);
    wait_result("bp_next");
    check_result("bp_next", 31'h20, 2'd1, 1'b0);
    handoff("bp_next");

    // Reset while the search is evaluating position j=10.
    send("rst_mid", 5'b00101, 5'b10001, 5'b11111, 5'b01100);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("rst_mid_in_ready_before", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready",      32'(bus.in_ready),      32'd1);
    check("rst_mid_out_valid",     32'(bus.out_valid),     32'd0);
    check("rst_mid_err_mask",      32'(bus.err_mask),      32'd0);
    check("rst_mid_err_count",     32'(bus.err_count),     32'd0);
    check("rst_mid_uncorrectable", 32'(bus.uncorrectable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release_in_ready", 32'(bus.in_ready), 32'd1);
    send("post_rst", 5'b00001, 5'b00001, 5'b00001, 5'b00001);
    wait_result("post_rst");
    check_result("post_rst", 31'h1, 2'd1, 1'b0);
    handoff("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
